// File: rtl/data_table_chain_search.sv
// Chained-bucket data table: owns the entry RAM and walks a chain of
// next_ptr links from a head pointer to find a key. A side write port lets
// the insert/delete engines edit entries, and a clear sequence zero-fills
// the whole RAM.
module data_table_chain_search #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MAX_HOPS    = 16,
  localparam int unsigned HW         = $clog2(MAX_HOPS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // search request
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [KEY_WIDTH-1:0]   req_key_i,
  input  logic [ADDR_WIDTH-1:0]  req_head_ptr_i,
  input  logic                   req_head_ptr_val_i,
  // search result
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   res_found_o,
  output logic [VALUE_WIDTH-1:0] res_value_o,
  output logic [ADDR_WIDTH-1:0]  res_addr_o,
  output logic [HW-1:0]          res_hops_o,
  output logic                   res_err_o,
  // side write port
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [KEY_WIDTH-1:0]   wr_key_i,
  input  logic [VALUE_WIDTH-1:0] wr_value_i,
  input  logic [ADDR_WIDTH-1:0]  wr_next_ptr_i,
  input  logic                   wr_next_ptr_val_i,
  // clear control / status
  input  logic                   clear_run_i,
  output logic                   clear_done_o,
  output logic                   busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    logic [ADDR_WIDTH-1:0]  next_ptr;
    logic                   next_ptr_val;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // RAM and its ports
  entry_t                  mem [DEPTH];
  entry_t                  rd_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic                    ram_wr_en_c;
  logic [ADDR_WIDTH-1:0]   ram_wr_addr_c;
  entry_t                  ram_wr_data_c;

  // control state
  state_t                  state_q, state_d;
  logic                    clear_pend_q, clear_pend_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [HW-1:0]           hops_q, hops_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

  // registered outputs
  logic                    res_valid_q, res_valid_d;
  logic                    res_found_q, res_found_d;
  logic [VALUE_WIDTH-1:0]  res_value_q, res_value_d;
  logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic [HW-1:0]           res_hops_q, res_hops_d;
  logic                    res_err_q, res_err_d;
  logic                    clear_done_q, clear_done_d;
  logic                    busy_q, busy_d;
  logic                    req_ready_c;

  // Port B source: zero-fill owns the port during CLEAR, user writes dropped
  always_comb begin
    ram_wr_en_c   = wr_en_i;
    ram_wr_addr_c = wr_addr_i;
    ram_wr_data_c = '{key: wr_key_i, value: wr_value_i,
                      next_ptr: wr_next_ptr_i, next_ptr_val: wr_next_ptr_val_i};
    if (state_q == S_CLEAR) begin
      ram_wr_en_c   = 1'b1;
      ram_wr_addr_c = clr_addr_q;
      ram_wr_data_c = '0;
    end
  end

  // Entry RAM: synchronous read returns old data on a same-address write
  always_ff @(posedge clk_i) begin
    if (ram_wr_en_c) begin
      mem[ram_wr_addr_c] <= ram_wr_data_c;
    end
    rd_q <= mem[rd_addr_c];
  end

  // Request handshake is only open in IDLE with no clear waiting
  assign req_ready_c = (state_q == S_IDLE) && !clear_pend_q && !clear_run_i;

  // Next-state, RAM read address and result computation
  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    key_d        = key_q;
    hops_d       = hops_q;
    cur_addr_d   = cur_addr_q;
    clr_addr_d   = clr_addr_q;
    res_valid_d  = res_valid_q;
    res_found_d  = res_found_q;
    res_value_d  = res_value_q;
    res_addr_d   = res_addr_q;
    res_hops_d   = res_hops_q;
    res_err_d    = res_err_q;
    clear_done_d = 1'b0;
    rd_addr_c    = '0;

    if (clear_run_i && (state_q != S_CLEAR)) begin
      clear_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_pend_q) begin
          state_d      = S_CLEAR;
          clear_pend_d = 1'b0;
          clr_addr_d   = '0;
        end else if (req_valid_i && req_ready_c) begin
          key_d = req_key_i;
          if (req_head_ptr_val_i) begin
            rd_addr_c  = req_head_ptr_i;
            cur_addr_d = req_head_ptr_i;
            hops_d     = HW'(1);
            state_d    = S_CMP;
          end else begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_found_d = 1'b0;
            res_value_d = '0;
            res_addr_d  = '0;
            res_hops_d  = '0;
            res_err_d   = 1'b0;
          end
        end
      end

      S_CMP: begin
        if (rd_q.key == key_q) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_found_d = 1'b1;
          res_value_d = rd_q.value;
          res_addr_d  = cur_addr_q;
          res_hops_d  = hops_q;
          res_err_d   = 1'b0;
        end else if (rd_q.next_ptr_val && (hops_q < HW'(MAX_HOPS))) begin
          rd_addr_c  = rd_q.next_ptr;
          cur_addr_d = rd_q.next_ptr;
          hops_d     = hops_q + HW'(1);
        end else begin
          // chain ended, or hop budget spent with a link still pending
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_found_d = 1'b0;
          res_value_d = '0;
          res_addr_d  = '0;
          res_hops_d  = hops_q;
          res_err_d   = rd_q.next_ptr_val;
        end
      end

      S_RESP: begin
        if (res_ready_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end

      S_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) || clear_pend_d;
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      clear_pend_q <= 1'b0;
      key_q        <= '0;
      hops_q       <= '0;
      cur_addr_q   <= '0;
      clr_addr_q   <= '0;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_value_q  <= '0;
      res_addr_q   <= '0;
      res_hops_q   <= '0;
      res_err_q    <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      key_q        <= key_d;
      hops_q       <= hops_d;
      cur_addr_q   <= cur_addr_d;
      clr_addr_q   <= clr_addr_d;
      res_valid_q  <= res_valid_d;
      res_found_q  <= res_found_d;
      res_value_q  <= res_value_d;
      res_addr_q   <= res_addr_d;
      res_hops_q   <= res_hops_d;
      res_err_q    <= res_err_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o  = req_ready_c;
  assign res_valid_o  = res_valid_q;
  assign res_found_o  = res_found_q;
  assign res_value_o  = res_value_q;
  assign res_addr_o   = res_addr_q;
  assign res_hops_o   = res_hops_q;
  assign res_err_o    = res_err_q;
  assign clear_done_o = clear_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_data_table_chain_search.sv
// Bench for data_table_chain_search: directed and random searches checked
// against an array model of the bucket RAM walked with plain loops.
module tb_data_table_chain_search;

  localparam int KW = 32;
  localparam int VW = 16;
  localparam int AW = 8;
  localparam int MAXH = 16;
  localparam int HWB = $clog2(MAXH + 1);
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [KW-1:0] req_key_i = '0;
  logic [AW-1:0] req_head_ptr_i = '0;
  logic          req_head_ptr_val_i = 1'b0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic          res_found_o;
  logic [VW-1:0] res_value_o;
  logic [AW-1:0] res_addr_o;
  logic [HWB-1:0] res_hops_o;
  logic          res_err_o;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [KW-1:0] wr_key_i = '0;
  logic [VW-1:0] wr_value_i = '0;
  logic [AW-1:0] wr_next_ptr_i = '0;
  logic          wr_next_ptr_val_i = 1'b0;
  logic          clear_run_i = 1'b0;
  logic          clear_done_o;
  logic          busy_o;

  int vectors = 0;
  int miscompares = 0;

  // reference model of the RAM
  logic [KW-1:0] m_key [DEPTH];
  logic [VW-1:0] m_val [DEPTH];
  logic [AW-1:0] m_np  [DEPTH];
  logic          m_npv [DEPTH];

  data_table_chain_search dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_head_ptr_i(req_head_ptr_i),
    .req_head_ptr_val_i(req_head_ptr_val_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_found_o(res_found_o), .res_value_o(res_value_o),
    .res_addr_o(res_addr_o), .res_hops_o(res_hops_o), .res_err_o(res_err_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_key_i(wr_key_i),
    .wr_value_i(wr_value_i), .wr_next_ptr_i(wr_next_ptr_i),
    .wr_next_ptr_val_i(wr_next_ptr_val_i),
    .clear_run_i(clear_run_i), .clear_done_o(clear_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the model chain: up to MAXH reads, err if a link is still pending
  task automatic model_search(input logic [KW-1:0] key, input logic [AW-1:0] head,
                              input logic hv, output logic found, output logic [VW-1:0] val,
                              output logic [AW-1:0] addr, output int hops, output logic err);
    logic [AW-1:0] p;
    logic done;
    found = 1'b0; val = '0; addr = '0; hops = 0; err = 1'b0; done = 1'b0;
    p = head;
    if (hv) begin
      for (int i = 0; i < MAXH; i++) begin
        if (!done) begin
          hops = i + 1;
          if (m_key[p] == key) begin
            found = 1'b1; val = m_val[p]; addr = p; done = 1'b1;
          end else if (!m_npv[p]) begin
            done = 1'b1;
          end else begin
            p = m_np[p];
          end
        end
      end
      if (!done) err = 1'b1;
    end
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [KW-1:0] k,
                             input logic [VW-1:0] v, input logic [AW-1:0] np, input logic npv);
    wr_en_i = 1'b1; wr_addr_i = a; wr_key_i = k; wr_value_i = v;
    wr_next_ptr_i = np; wr_next_ptr_val_i = npv;
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
    m_key[a] = k; m_val[a] = v; m_np[a] = np; m_npv[a] = npv;
  endtask

  // One search; optionally a port-B write lands in the accept cycle
  task automatic search(input string tag, input logic [KW-1:0] key, input logic [AW-1:0] head,
                        input logic hv, input logic do_wr, input logic [AW-1:0] wa,
                        input logic [KW-1:0] wk, input logic [VW-1:0] wv);
    logic e_found, e_err;
    logic [VW-1:0] e_val;
    logic [AW-1:0] e_addr;
    int e_hops, lat;
    model_search(key, head, hv, e_found, e_val, e_addr, e_hops, e_err);
    check({tag, ".req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_key_i = key; req_head_ptr_i = head; req_head_ptr_val_i = hv;
    if (do_wr) begin
      wr_en_i = 1'b1; wr_addr_i = wa; wr_key_i = wk; wr_value_i = wv;
      wr_next_ptr_i = '0; wr_next_ptr_val_i = 1'b0;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; wr_en_i = 1'b0;
    if (do_wr) begin
      m_key[wa] = wk; m_val[wa] = wv; m_np[wa] = '0; m_npv[wa] = 1'b0;
    end
    lat = 1;
    while (!res_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(hv ? e_hops + 1 : 1));
    check({tag, ".found"}, 64'(res_found_o), 64'(e_found));
    check({tag, ".value"}, 64'(res_value_o), 64'(e_val));
    check({tag, ".addr"}, 64'(res_addr_o), 64'(e_addr));
    check({tag, ".hops"}, 64'(res_hops_o), 64'(e_hops));
    check({tag, ".err"}, 64'(res_err_o), 64'(e_err));
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
  endtask

  // Pulse clear_run_i and time clear_done_o, with a dropped write inside
  task automatic run_clear();
    int cnt;
    logic all_busy;
    clear_run_i = 1'b1;
    @(posedge clk_i); #1;
    clear_run_i = 1'b0;
    cnt = 0; all_busy = 1'b1;
    while (!clear_done_o && cnt < 400) begin
      @(posedge clk_i); #1;
      cnt++;
      wr_en_i = 1'b0;
      if (!clear_done_o) all_busy &= busy_o;
      if (cnt == 5) check("clear.req_ready_low", 64'(req_ready_o), 64'd0);
      if (cnt == 10) begin
        wr_en_i = 1'b1; wr_addr_i = 8'd7; wr_key_i = 32'hDEAD; wr_value_i = 16'hBEEF;
        wr_next_ptr_i = 8'd1; wr_next_ptr_val_i = 1'b1;
      end
    end
    wr_en_i = 1'b0;
    check("clear.done_cycles", 64'(cnt), 64'd257);
    check("clear.busy_throughout", 64'(all_busy), 64'd1);
    @(posedge clk_i); #1;
    check("clear.done_one_cycle", 64'(clear_done_o), 64'd0);
    check("clear.busy_after", 64'(busy_o), 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      m_key[a] = '0; m_val[a] = '0; m_np[a] = '0; m_npv[a] = 1'b0;
    end
  endtask

  initial begin
    logic stable, rdy_low, seen_valid;
    int lat;
    for (int a = 0; a < DEPTH; a++) begin
      m_key[a] = 'x; m_val[a] = 'x; m_np[a] = 'x; m_npv[a] = 1'bx;
    end
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("reset.res_valid", 64'(res_valid_o), 64'd0);
    check("reset.req_ready", 64'(req_ready_o), 64'd1);
    check("reset.busy", 64'(busy_o), 64'd0);
    check("reset.clear_done", 64'(clear_done_o), 64'd0);
    check("reset.res_fields", {res_found_o, res_value_o, res_addr_o, res_hops_o, res_err_o}, 64'd0);
    @(posedge clk_i); #1;

    // zero-fill then read every word back (key 0 hits the zeroed entry)
    run_clear();
    for (int a = 0; a < DEPTH; a++) search("sweep", '0, AW'(a), 1'b1, 1'b0, '0, '0, '0);

    // empty bucket
    search("empty", 32'h10, 8'd3, 1'b0, 1'b0, '0, '0, '0);

    // chain 5 -> 9 -> 2
    write_entry(8'd5, 32'h11, 16'h0505, 8'd9, 1'b1);
    write_entry(8'd9, 32'h22, 16'h0909, 8'd2, 1'b1);
    write_entry(8'd2, 32'hAB, 16'h1234, 8'd0, 1'b0);
    search("chain_hit", 32'hAB, 8'd5, 1'b1, 1'b0, '0, '0, '0);
    search("chain_mid", 32'h22, 8'd5, 1'b1, 1'b0, '0, '0, '0);
    search("chain_miss", 32'hCD, 8'd5, 1'b1, 1'b0, '0, '0, '0);

    // self loop hits the hop limit
    write_entry(8'd4, 32'h44, 16'h4444, 8'd4, 1'b1);
    search("loop", 32'h99, 8'd4, 1'b1, 1'b0, '0, '0, '0);

    // same-address write in the accept cycle: the search sees old data
    write_entry(8'd20, 32'h55, 16'h0077, 8'd0, 1'b0);
    search("rdw_old", 32'h55, 8'd20, 1'b1, 1'b1, 8'd20, 32'h66, 16'h0088);
    search("rdw_new", 32'h66, 8'd20, 1'b1, 1'b0, '0, '0, '0);

    // random chains in a small address window with a small key pool
    for (int i = 0; i < 48; i++) begin
      write_entry(AW'($urandom_range(32, 63)), KW'(32'h100 + $urandom_range(0, 7)),
                  VW'($urandom), AW'($urandom_range(32, 63)), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) begin
      search("rand", KW'(32'h100 + $urandom_range(0, 8)), AW'($urandom_range(32, 63)),
             1'($urandom_range(0, 7) != 0), 1'b0, '0, '0, '0);
    end

    // backpressure: result held stable, no new request accepted
    req_valid_i = 1'b1; req_key_i = 32'hAB; req_head_ptr_i = 8'd5; req_head_ptr_val_i = 1'b1;
    @(posedge clk_i); #1;
    lat = 1;
    while (!res_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("bp.latency", 64'(lat), 64'd4);
    stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      stable &= res_valid_o && res_found_o && (res_value_o == 16'h1234) &&
                (res_addr_o == 8'd2) && (res_hops_o == HWB'(3)) && !res_err_o;
      rdy_low &= !req_ready_o;
    end
    check("bp.stable", 64'(stable), 64'd1);
    check("bp.req_ready_low", 64'(rdy_low), 64'd0 | 64'd1);
    req_valid_i = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    check("bp.released", 64'(res_valid_o), 64'd0);

    // reset in the middle of the long self-loop walk
    req_valid_i = 1'b1; req_key_i = 32'h99; req_head_ptr_i = 8'd4; req_head_ptr_val_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("rst_mid.res_valid", 64'(res_valid_o), 64'd0);
    check("rst_mid.busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      seen_valid |= res_valid_o;
    end
    check("rst_mid.no_response", 64'(seen_valid), 64'd0);
    check("rst_mid.req_ready", 64'(req_ready_o), 64'd1);

    // clear requested while a search is in flight: search completes first
    req_valid_i = 1'b1; req_key_i = 32'h99; req_head_ptr_i = 8'd4; req_head_ptr_val_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    clear_run_i = 1'b1;
    @(posedge clk_i); #1;
    clear_run_i = 1'b0;
    lat = 3;
    while (!res_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("clr_mid.latency", 64'(lat), 64'd17);
    check("clr_mid.err", 64'(res_err_o), 64'd1);
    check("clr_mid.hops", 64'(res_hops_o), 64'd16);
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    check("clr_mid.busy_pending", 64'(busy_o), 64'd1);
    check("clr_mid.req_ready", 64'(req_ready_o), 64'd0);
    lat = 0;
    while (!clear_done_o && lat < 400) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("clr_mid.done_cycles", 64'(lat), 64'd257);
    for (int a = 0; a < DEPTH; a++) begin
      m_key[a] = '0; m_val[a] = '0; m_np[a] = '0; m_npv[a] = 1'b0;
    end
    @(posedge clk_i); #1;
    search("clr_mid.zeroed", '0, 8'd4, 1'b1, 1'b0, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
